// File: rtl/accelerator_tensor_pkg.sv
// Shared types and constants for the tensor float feeder.
// Holds the FSM state encoding and zero/one constants.
package accelerator_tensor_pkg;

  localparam int CONTROL_W = 64;
  localparam int DATA_W    = 64;

  typedef enum logic [2:0] {
    STARTER_STATE = 3'd0,
    ISSUE_STATE   = 3'd1,
    WAIT_STATE    = 3'd2,
    EMIT_STATE    = 3'd3,
    ENDER_STATE   = 3'd4
  } state_t;

  localparam logic [CONTROL_W-1:0] ZERO_CONTROL = '0;
  localparam logic [CONTROL_W-1:0] ONE_CONTROL  =
    {{(CONTROL_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0]    ZERO_DATA    = '0;
  localparam logic [DATA_W-1:0]    ONE_DATA     =
    {{(DATA_W-1){1'b0}}, 1'b1};

endpackage

// File: rtl/accelerator_tensor_float_feeder_index.sv
// Nested i/j/k index counter with clear, step and wrap.
// Ports: clk_i/rst_i, clear_i, step_i, sizes in, i/j/k out, last_o.
module accelerator_tensor_index_counter
  import accelerator_tensor_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         step_i,
  input  logic [W-1:0] size_i_i,
  input  logic [W-1:0] size_j_i,
  input  logic [W-1:0] size_k_i,
  output logic [W-1:0] i_o,
  output logic [W-1:0] j_o,
  output logic [W-1:0] k_o,
  output logic         last_o
);

  localparam logic [W-1:0] ZERO = W'(ZERO_CONTROL);
  localparam logic [W-1:0] ONE  = W'(ONE_CONTROL);

  logic [W-1:0] i_q, i_d;
  logic [W-1:0] j_q, j_d;
  logic [W-1:0] k_q, k_d;
  logic         j_wrap, k_wrap;

  assign k_wrap = (k_q == size_k_i - ONE);
  assign j_wrap = (j_q == size_j_i - ONE);

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (clear_i) begin
      i_d = ZERO;
      j_d = ZERO;
      k_d = ZERO;
    end else if (step_i) begin
      if (k_wrap) begin
        k_d = ZERO;
        if (j_wrap) begin
          j_d = ZERO;
          i_d = i_q + ONE;
        end else begin
          j_d = j_q + ONE;
        end
      end else begin
        k_d = k_q + ONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      i_q <= ZERO;
      j_q <= ZERO;
      k_q <= ZERO;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

  assign i_o    = i_q;
  assign j_o    = j_q;
  assign k_o    = k_q;
  assign last_o = (i_q == size_i_i - ONE) && j_wrap && k_wrap;

endmodule

// File: rtl/accelerator_tensor_float_feeder.sv
// Streams a row-major 3-D tensor from a sync-read memory.
// Ports: START/READY control, READ_* memory, DATA_OUT + I/J/K strobes.
module accelerator_tensor_float_feeder
  import accelerator_tensor_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [CONTROL_SIZE-1:0] SIZE_I_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_J_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_K_IN,
  input  logic [CONTROL_SIZE-1:0] BASE_ADDRESS_IN,
  output logic                    READ_ENABLE,
  output logic [CONTROL_SIZE-1:0] READ_ADDRESS,
  input  logic [DATA_SIZE-1:0]    READ_DATA,
  input  logic                    ADVANCE,
  output logic [DATA_SIZE-1:0]    DATA_OUT,
  output logic                    DATA_OUT_I_ENABLE,
  output logic                    DATA_OUT_J_ENABLE,
  output logic                    DATA_OUT_K_ENABLE
);

  localparam logic [CONTROL_SIZE-1:0] CZERO = CONTROL_SIZE'(ZERO_CONTROL);
  localparam logic [CONTROL_SIZE-1:0] CONE  = CONTROL_SIZE'(ONE_CONTROL);
  localparam logic [DATA_SIZE-1:0]    DZERO = DATA_SIZE'(ZERO_DATA);

  state_t                  state_q, state_d;
  logic [CONTROL_SIZE-1:0] size_i_q, size_i_d;
  logic [CONTROL_SIZE-1:0] size_j_q, size_j_d;
  logic [CONTROL_SIZE-1:0] size_k_q, size_k_d;
  logic [CONTROL_SIZE-1:0] addr_q, addr_d;
  logic [DATA_SIZE-1:0]    data_q, data_d;
  logic [2:0]              en_q, en_d;

  logic                    clear, step, last, empty;
  logic [CONTROL_SIZE-1:0] idx_i, idx_j, idx_k;

  accelerator_tensor_index_counter #(
    .W(CONTROL_SIZE)
  ) u_index (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clear_i (clear),
    .step_i  (step),
    .size_i_i(size_i_q),
    .size_j_i(size_j_q),
    .size_k_i(size_k_q),
    .i_o     (idx_i),
    .j_o     (idx_j),
    .k_o     (idx_k),
    .last_o  (last)
  );

  // Zero-size tensors pass through ISSUE without reading.
  assign empty = (size_i_q == CZERO) ||
                 (size_j_q == CZERO) ||
                 (size_k_q == CZERO);

  always_comb begin
    state_d  = state_q;
    size_i_d = size_i_q;
    size_j_d = size_j_q;
    size_k_d = size_k_q;
    addr_d   = addr_q;
    data_d   = data_q;
    en_d     = en_q;
    clear    = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      STARTER_STATE: begin
        if (START) begin
          size_i_d = SIZE_I_IN;
          size_j_d = SIZE_J_IN;
          size_k_d = SIZE_K_IN;
          addr_d   = BASE_ADDRESS_IN;
          clear    = 1'b1;
          state_d  = ISSUE_STATE;
        end
      end
      ISSUE_STATE: begin
        state_d = empty ? ENDER_STATE : WAIT_STATE;
      end
      WAIT_STATE: begin
        data_d  = READ_DATA;
        en_d    = {(idx_j == CZERO) && (idx_k == CZERO),
                   (idx_k == CZERO), 1'b1};
        state_d = EMIT_STATE;
      end
      EMIT_STATE: begin
        if (ADVANCE) begin
          en_d    = 3'b000;
          addr_d  = addr_q + CONE;
          step    = 1'b1;
          state_d = last ? ENDER_STATE : ISSUE_STATE;
        end
      end
      ENDER_STATE: begin
        state_d = STARTER_STATE;
      end
      default: begin
        state_d = STARTER_STATE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= STARTER_STATE;
      size_i_q <= CZERO;
      size_j_q <= CZERO;
      size_k_q <= CZERO;
      addr_q   <= CZERO;
      data_q   <= DZERO;
      en_q     <= 3'b000;
    end else begin
      state_q  <= state_d;
      size_i_q <= size_i_d;
      size_j_q <= size_j_d;
      size_k_q <= size_k_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      en_q     <= en_d;
    end
  end

  assign READY             = (state_q == ENDER_STATE);
  assign READ_ENABLE       = (state_q == ISSUE_STATE) && !empty;
  assign READ_ADDRESS      = addr_q;
  assign DATA_OUT          = data_q;
  assign DATA_OUT_I_ENABLE = en_q[2];
  assign DATA_OUT_J_ENABLE = en_q[1];
  assign DATA_OUT_K_ENABLE = en_q[0];

endmodule
